// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit multiply/divide unit holding the HI/LO
// architectural registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
//
// An operation walks IDLE -> PREP -> RUN (WIDTH cycles) -> FIXUP -> DONE.
// PREP takes the operand magnitudes and records the result signs. RUN
// retires one bit per cycle: shift-add for multiply, restoring
// shift-subtract for divide. FIXUP applies the sign correction, and the
// edge that leaves FIXUP writes {HI,LO}. DONE lasts one cycle, and a new
// start is accepted there exactly as in IDLE.
//
// Handshake: start_i is sampled on a rising edge. It is accepted only
// while busy_o is low (IDLE or DONE) and only if abort_i is low. busy_o
// stays high from the cycle after acceptance until the result is written.
// done_o pulses for one cycle, WIDTH+2 edges after the accepting edge.
// dz_o is meaningful only while done_o is high.
//
// Ports:
//   clk_i, rst_i            clock; asynchronous active-high reset
//   start_i, op_i           request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   rs_data_i, rt_data_i    multiplicand/dividend, multiplier/divisor
//   abort_i                 cancels an in-flight operation
//   hi_we_i, lo_we_i        MTHI/MTLO strobes, honoured only while not busy
//   wdata_i                 MTHI/MTLO data
//   busy_o, done_o, dz_o    status (all registered)
//   hi_o, lo_o              HI/LO registers
//   state_o                 current FSM state, for debug visibility
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             abort_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             dz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [2:0]       state_o
);

  localparam int         W2       = 2 * WIDTH;
  localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_RUN   = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  rs_q, rs_d;
  logic [WIDTH-1:0]  rt_q, rt_d;
  logic [WIDTH-1:0]  mag_b_q, mag_b_d;
  logic [W2-1:0]     prod_q, prod_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;

  // Operation decode, from the latched opcode.
  logic is_div, is_signed;
  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  // Magnitudes for PREP. The magnitude of the most negative value is
  // 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign a_neg = is_signed & rs_q[WIDTH-1];
  assign b_neg = is_signed & rt_q[WIDTH-1];
  assign mag_a = a_neg ? -rs_q : rs_q;
  assign mag_b = b_neg ? -rt_q : rt_q;

  // Multiply step. prod_q holds {accumulator, remaining multiplier bits}.
  // The LSB selects whether to add, and the carry shifts into the top.
  logic [WIDTH:0]  mul_sum;
  logic [W2-1:0]   mul_step;
  assign mul_sum  = {1'b0, prod_q[W2-1:WIDTH]} +
                    (prod_q[0] ? {1'b0, mag_b_q} : {(WIDTH+1){1'b0}});
  assign mul_step = {mul_sum, prod_q[WIDTH-1:1]};

  // Divide step. prod_q holds {partial remainder, dividend/quotient bits}.
  // The shifted remainder is WIDTH+1 bits. When it is >= divisor the
  // difference is below the divisor, so its low WIDTH bits are exact.
  logic [WIDTH:0]   rem_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [W2-1:0]    div_step;
  assign rem_shift = prod_q[W2-1:WIDTH-1];
  assign div_ge    = rem_shift >= {1'b0, mag_b_q};
  assign div_diff  = prod_q[W2-2:WIDTH-1] - mag_b_q;
  assign div_step  = div_ge ? {div_diff, prod_q[WIDTH-2:0], 1'b1}
                            : {prod_q[W2-2:0], 1'b0};

  // Sign fixup. A zero divisor bypasses the datapath result: LO is all
  // ones and HI is the original (signed) dividend.
  logic             div_zero;
  logic [W2-1:0]    mul_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign div_zero = is_div && (rt_q == '0);
  assign mul_fix  = neg_res_q ? -prod_q : prod_q;
  assign quo_fix  = neg_res_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -prod_q[W2-1:WIDTH] : prod_q[W2-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    mag_b_d   = mag_b_q;
    prod_d    = prod_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = 1'b0;

    // MTHI/MTLO land only while the unit is idle. A write on the same
    // edge as an accepted start still happens; the later result overwrites it.
    if (!busy_q) begin
      if (hi_we_i) hi_d = wdata_i;
      if (lo_we_i) lo_d = wdata_i;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i && !abort_i) begin
          state_d = S_PREP;
          op_d    = op_i;
          rs_d    = rs_data_i;
          rt_d    = rt_data_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        prod_d    = {{WIDTH{1'b0}}, mag_a};
        mag_b_d   = mag_b;
        neg_res_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        cnt_d     = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        prod_d = is_div ? div_step : mul_step;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        if (!is_div) begin
          hi_d = mul_fix[W2-1:WIDTH];
          lo_d = mul_fix[WIDTH-1:0];
        end else if (div_zero) begin
          hi_d = rs_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        dz_d    = div_zero;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // An abort cancels everything an in-flight operation would do,
    // including a result write from FIXUP.
    if (busy_q && abort_i) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = 1'b0;
    end

    busy_d = (state_d == S_PREP) || (state_d == S_RUN) || (state_d == S_FIXUP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      mag_b_q   <= '0;
      prod_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      mag_b_q   <= mag_b_d;
      prod_q    <= prod_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign dz_o    = dz_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign state_o = state_q;

endmodule
